// File: rtl/magnetron_duty_ctrl.sv
`timescale 1ns/1ps
// Magnetron session controller: idle/cook/paused FSM with a tick-driven duty window.
// The power level is latched at session start and gates mag_on over each CYCLE_LEN-tick window.
module magnetron_duty_ctrl #(
  parameter int unsigned CYCLE_LEN = 10,
  parameter int unsigned LEVEL_W   = $clog2(CYCLE_LEN + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               startn,
  input  logic               stopn,
  input  logic               clearn,
  input  logic               door_closed,
  input  logic               timer_done,
  input  logic               tick,
  input  logic [LEVEL_W-1:0] power_level,
  output logic               mag_on,
  output logic               cooking,
  output logic               paused,
  output logic               done
);

  localparam int unsigned LW = $clog2(CYCLE_LEN + 1);
  localparam int unsigned PW = $clog2(CYCLE_LEN);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCook   = 2'd1,
    StPaused = 2'd2,
    StBad    = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [LW-1:0] lvl_q, lvl_d, lvl_sat;
  logic          mag_on_q, mag_on_d;
  logic          done_q, done_d;
  logic          start_ok;

  always_comb begin
    if (32'(power_level) >= CYCLE_LEN) begin
      lvl_sat = LW'(CYCLE_LEN);
    end else begin
      lvl_sat = LW'(power_level);
    end
  end

  assign start_ok = !startn && door_closed && !timer_done;

  // Branch order inside each state mirrors the transition priority.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (!clearn) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_ok) state_d = StCook;
        end
        StCook: begin
          if (!door_closed || !stopn) begin
            state_d = StPaused;
          end else if (timer_done) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
        StPaused: begin
          if (!stopn && startn) begin
            state_d = StIdle;
          end else if (start_ok) begin
            state_d = StCook;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    lvl_d   = lvl_q;
    phase_d = phase_q;
    if (state_d == StIdle) begin
      phase_d = '0;
    end else if (state_q == StIdle && state_d == StCook) begin
      phase_d = '0;
      lvl_d   = lvl_sat;
    end else if (state_q == StCook && state_d == StCook && tick) begin
      phase_d = (phase_q == PW'(CYCLE_LEN - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  assign mag_on_d = (state_d == StCook) && (32'(phase_d) < 32'(lvl_d));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      phase_q  <= '0;
      lvl_q    <= '0;
      mag_on_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      lvl_q    <= lvl_d;
      mag_on_q <= mag_on_d;
      done_q   <= done_d;
    end
  end

  assign mag_on  = mag_on_q;
  assign done    = done_q;
  assign cooking = (state_q == StCook);
  assign paused  = (state_q == StPaused);

endmodule

// File: tb/tb_magnetron_duty_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench: a driver pushes model predictions per edge, a monitor pops and compares.
// The model counts ticks per session and derives the duty phase arithmetically.
module tb_magnetron_duty_ctrl;

  localparam int unsigned CYCLE = 10;
  localparam int unsigned LW    = $clog2(CYCLE + 1);
  localparam int MIdle = 0, MCook = 1, MPaused = 2;

  typedef struct {
    bit mag;
    bit cook;
    bit pause;
    bit dn;
  } exp_t;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          startn = 1'b1, stopn = 1'b1, clearn = 1'b1;
  logic          door_closed = 1'b1, timer_done = 1'b0, tick = 1'b0;
  logic [LW-1:0] power_level = '0;
  logic          mag_on, cooking, paused, done;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int m_st = MIdle;
  int m_ticks = 0;
  int m_lvl = 0;

  magnetron_duty_ctrl #(.CYCLE_LEN(CYCLE)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .startn      (startn),
    .stopn       (stopn),
    .clearn      (clearn),
    .door_closed (door_closed),
    .timer_done  (timer_done),
    .tick        (tick),
    .power_level (power_level),
    .mag_on      (mag_on),
    .cooking     (cooking),
    .paused      (paused),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and predict the outputs after the following rising edge.
  task automatic step(input bit rn, input bit clr, input bit st, input bit sp, input bit dc,
                      input bit td, input bit tk, input int pl);
    exp_t e;
    int   nst;
    bit   dn;
    @(negedge clk);
    resetn      = rn;
    clearn      = clr;
    startn      = st;
    stopn       = sp;
    door_closed = dc;
    timer_done  = td;
    tick        = tk;
    power_level = LW'(pl);
    dn = 1'b0;
    if (!rn) begin
      m_st = MIdle; m_ticks = 0; m_lvl = 0;
      e = '{mag: 1'b0, cook: 1'b0, pause: 1'b0, dn: 1'b0};
    end else begin
      nst = m_st;
      if (!clr) nst = MIdle;
      else if (m_st == MCook && (!dc || !sp)) nst = MPaused;
      else if (m_st == MPaused && !sp && st) nst = MIdle;
      else if (m_st == MCook && td) begin nst = MIdle; dn = 1'b1; end
      else if (m_st != MCook && !st && dc && !td) nst = MCook;
      if (m_st == MIdle && nst == MCook) begin
        m_lvl   = (pl >= int'(CYCLE)) ? int'(CYCLE) : pl;
        m_ticks = 0;
      end else if (m_st == MCook && nst == MCook && tk) begin
        m_ticks++;
      end
      if (nst == MIdle) m_ticks = 0;
      m_st = nst;
      e.mag   = (nst == MCook) && ((m_ticks % int'(CYCLE)) < m_lvl);
      e.cook  = (nst == MCook);
      e.pause = (nst == MPaused);
      e.dn    = dn;
    end
    exp_q.push_back(e);
  endtask

  task automatic idle_cycles(input int n, input int pl);
    for (int i = 0; i < n; i++) step(1, 1, 1, 1, 1, 0, 0, pl);
  endtask

  task automatic ticks(input int n, input int period, input int pl);
    for (int i = 0; i < n * period; i++) step(1, 1, 1, 1, 1, 0, (i % period) == 0, pl);
  endtask

  // Monitor: one expected entry per rising edge, sampled just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vectors++;
        if ({mag_on, cooking, paused, done} !== {e.mag, e.cook, e.pause, e.dn}) begin
          miscompares++;
          $display("FAIL outputs at %0t: mag_on/cooking/paused/done got %b%b%b%b want %b%b%b%b",
                   $time, mag_on, cooking, paused, done, e.mag, e.cook, e.pause, e.dn);
        end
      end
    end
  end

  initial begin
    step(0, 1, 1, 1, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1, 0, 0, 0);
    idle_cycles(2, 3);

    // Level 3, tick every 4 clocks for 20 ticks.
    step(1, 1, 0, 1, 1, 0, 0, 3);
    ticks(20, 4, 3);

    // Level 0 then saturating level 15.
    step(1, 0, 1, 1, 1, 0, 0, 0);
    step(1, 1, 0, 1, 1, 0, 0, 0);
    ticks(12, 2, 0);
    step(1, 0, 1, 1, 1, 0, 0, 15);
    step(1, 1, 0, 1, 1, 0, 0, 15);
    ticks(12, 2, 9);

    // Level 5, reach phase 2, open door, close and resume.
    step(1, 0, 1, 1, 1, 0, 0, 5);
    step(1, 1, 0, 1, 1, 0, 0, 5);
    step(1, 1, 1, 1, 1, 0, 1, 5);
    step(1, 1, 1, 1, 1, 0, 1, 5);
    step(1, 1, 1, 1, 0, 0, 1, 5);
    step(1, 1, 1, 1, 1, 0, 1, 5);
    step(1, 1, 0, 1, 1, 0, 0, 1);
    ticks(8, 1, 1);

    // Timer expiry, then clear together with timer_done.
    step(1, 1, 1, 1, 1, 1, 0, 4);
    idle_cycles(2, 4);
    step(1, 1, 0, 1, 1, 0, 0, 4);
    step(1, 0, 1, 1, 1, 1, 0, 4);
    idle_cycles(1, 4);

    // Pause via stop, cancel via stop; door-open start in idle; both low in paused resumes.
    step(1, 1, 0, 1, 1, 0, 0, 6);
    step(1, 1, 1, 0, 1, 0, 0, 6);
    step(1, 1, 1, 0, 1, 0, 0, 6);
    step(1, 1, 0, 1, 0, 0, 0, 6);
    step(1, 1, 0, 1, 1, 0, 0, 6);
    step(1, 1, 1, 0, 1, 0, 1, 6);
    step(1, 1, 0, 0, 1, 0, 1, 6);
    step(1, 1, 1, 1, 0, 1, 1, 6);

    // Asynchronous reset mid-window while the magnetron is on.
    step(1, 0, 1, 1, 1, 0, 0, 10);
    step(1, 1, 0, 1, 1, 0, 0, 10);
    step(1, 1, 1, 1, 1, 0, 1, 10);
    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    vectors++;
    if ({mag_on, cooking, paused, done} !== 4'b0000) begin
      miscompares++;
      $display("FAIL async_reset: outputs got %b%b%b%b want 0000", mag_on, cooking, paused,
               done);
    end
    step(0, 1, 1, 1, 1, 0, 0, 2);
    step(1, 1, 0, 1, 1, 0, 0, 2);
    ticks(12, 1, 2);

    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 99) >= 3),
           ($urandom_range(0, 99) >= 20), ($urandom_range(0, 99) >= 8),
           ($urandom_range(0, 99) >= 10), ($urandom_range(0, 99) < 5),
           ($urandom_range(0, 99) < 35), int'($urandom_range(0, 15)));
    end

    repeat (3) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
